// File: rtl/addsub_pipe.sv
// Pipelined, stall-able adder/subtractor: one CHUNK-bit carry-lookahead slice per stage,
// with the ripple carry, valid bit and tag registered alongside each operation.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             as,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [TAGW-1:0]  tag_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAGW-1:0]  tag_out
);

  localparam int STAGES = WIDTH / CHUNK;

  generate
    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("addsub_pipe: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end
    if (TAGW < 1) begin : g_bad_tagw
      $error("addsub_pipe: TAGW (%0d) must be at least 1", TAGW);
    end
  endgenerate

  // Handshake: there is no back-pressure. An operation is accepted on every rising edge
  // where en=1 and in_valid=1; its result appears with out_valid=1 after STAGES further
  // enabled edges. en=0 freezes the whole pipe, and inputs seen while en=0 are dropped.

  // Returns {carry into MSB, carry out, sum}. Each carry is expanded in lookahead
  // form from g/p terms and cin so no carry depends on a previous carry signal.
  function automatic logic [CHUNK+1:0] cla(input logic [CHUNK-1:0] a,
                                           input logic [CHUNK-1:0] b,
                                           input logic             cin);
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] s;
    logic [CHUNK:0]   c;
    logic             term;
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      term = cin;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    s = p ^ c[CHUNK-1:0];
    return {c[CHUNK-1], c[CHUNK], s};
  endfunction

  // Operands are only needed until their chunk has been consumed, so the last stage
  // carries none; r_q[0] is a constant empty result feeding stage 1.
  logic [WIDTH-1:0] a_q   [0:STAGES-1];
  logic [WIDTH-1:0] b_q   [0:STAGES-1];
  logic [WIDTH-1:0] r_q   [0:STAGES];
  logic             c_q   [0:STAGES];
  logic             v_q   [0:STAGES];
  logic [TAGW-1:0]  t_q   [0:STAGES];
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK+1:0] cla_res [1:STAGES];
  logic [WIDTH-1:0] r_nxt   [1:STAGES];

  always_comb begin
    for (int s = 1; s <= STAGES; s++) begin
      cla_res[s] = cla(a_q[s-1][(s-1)*CHUNK +: CHUNK],
                       b_q[s-1][(s-1)*CHUNK +: CHUNK],
                       c_q[s-1]);
      r_nxt[s] = r_q[s-1];
      r_nxt[s][(s-1)*CHUNK +: CHUNK] = cla_res[s][CHUNK-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
      end
      for (int s = 0; s <= STAGES; s++) begin
        r_q[s] <= '0;
        c_q[s] <= 1'b0;
        v_q[s] <= 1'b0;
        t_q[s] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      // Subtraction is a + ~b + 1: invert b here and inject the +1 as carry-in.
      a_q[0] <= in1;
      b_q[0] <= in2 ^ {WIDTH{as}};
      r_q[0] <= '0;
      c_q[0] <= as;
      v_q[0] <= in_valid;
      t_q[0] <= tag_in;
      for (int s = 1; s < STAGES; s++) begin
        a_q[s] <= a_q[s-1];
        b_q[s] <= b_q[s-1];
      end
      for (int s = 1; s <= STAGES; s++) begin
        r_q[s] <= r_nxt[s];
        c_q[s] <= cla_res[s][CHUNK];
        v_q[s] <= v_q[s-1];
        t_q[s] <= t_q[s-1];
      end
      ovf_q  <= cla_res[STAGES][CHUNK+1] ^ cla_res[STAGES][CHUNK];
      zero_q <= (r_nxt[STAGES] == '0);
    end
  end

  assign out_valid = v_q[STAGES];
  assign out       = r_q[STAGES];
  assign cout      = c_q[STAGES];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign tag_out   = t_q[STAGES];

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: expected results and their due enabled-edge are
// queued at issue and compared when the pipeline output is sampled.
module tb_addsub_pipe;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int TAGW   = 4;
  localparam int STAGES = WIDTH / CHUNK;
  localparam int W      = TAGW + 3 + WIDTH;

  logic             clk;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic             as;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [TAGW-1:0]  tag_in;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAGW-1:0]  tag_out;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [W-1:0] exp_q[$];
  int           due_q[$];
  logic [W:0]   snap;
  logic [W:0]   cur;
  logic         exp_v;

  addsub_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAGW(TAGW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .as       (as),
    .in1      (in1),
    .in2      (in2),
    .tag_in   (tag_in),
    .out_valid(out_valid),
    .out      (out),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .tag_out  (tag_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pack(input logic [TAGW-1:0] tag, input logic z,
                                        input logic o, input logic c,
                                        input logic [WIDTH-1:0] r);
    return {tag, z, o, c, r};
  endfunction

  // Reference model: plain integer arithmetic with sign-rule overflow.
  function automatic logic [W-1:0] model(input logic sub, input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [TAGW-1:0] tag);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] r;
    logic             o;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    else     full = {1'b0, a} + {1'b0, b};
    r = full[WIDTH-1:0];
    if (sub) o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    else     o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    return pack(tag, (r == '0), o, full[WIDTH], r);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Driver tasks: inputs change on the falling edge only.
  task automatic drive(input logic v, input logic sub, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag,
                       input logic [W-1:0] e);
    @(negedge clk);
    en       = 1'b1;
    in_valid = v;
    as       = sub;
    in1      = a;
    in2      = b;
    tag_in   = tag;
    if (v) begin
      exp_q.push_back(e);
      due_q.push_back(edge_n + 1 + STAGES);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    logic [WIDTH-1:0] msb;
    msb = '0;
    msb[WIDTH-1] = 1'b1;
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return msb;
      3:       return {{(WIDTH-1){1'b0}}, 1'b1};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic issue_rand(input logic v);
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAGW-1:0]  tag;
    sub = 1'($urandom_range(0, 1));
    a   = rand_operand();
    b   = rand_operand();
    tag = TAGW'($urandom);
    drive(v, sub, a, b, tag, model(sub, a, b, tag));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  // Garbage presented during a stall must be ignored, so it is never queued.
  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      en       = 1'b0;
      in_valid = 1'b1;
      as       = 1'($urandom_range(0, 1));
      in1      = WIDTH'($urandom);
      in2      = WIDTH'($urandom);
      tag_in   = TAGW'($urandom);
    end
  endtask

  // Scoreboard: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      snap = '0;
    end else begin
      cur = {out_valid, tag_out, zero, ovf, cout, out};
      if (en) begin
        edge_n++;
        while (due_q.size() > 0 && due_q[0] < edge_n) begin
          void'(due_q.pop_front());
          void'(exp_q.pop_front());
        end
        exp_v = (due_q.size() > 0) && (due_q[0] == edge_n);
        check("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v && out_valid) begin
          check("result", 64'({tag_out, zero, ovf, cout, out}), 64'(exp_q[0]));
          void'(due_q.pop_front());
          void'(exp_q.pop_front());
        end
      end else begin
        check("stall_hold", 64'(cur), 64'(snap));
      end
      snap = cur;
    end
  end

  logic pattern [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; as = 1'b0;
    in1 = '0; in2 = '0; tag_in = '0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({out_valid, tag_out, zero, ovf, cout, out}), 64'(0));
    rst = 1'b0;

    // Directed corner cases with hand-derived expectations
    drive(1'b1, 1'b0, 16'h7FFF, 16'h0001, 4'h3, pack(4'h3, 1'b0, 1'b1, 1'b0, 16'h8000));
    idle(6);
    drive(1'b1, 1'b0, 16'hFFFF, 16'h0001, 4'h5, pack(4'h5, 1'b1, 1'b0, 1'b1, 16'h0000));
    drive(1'b1, 1'b1, 16'h0005, 16'h0007, 4'h6, pack(4'h6, 1'b0, 1'b0, 1'b0, 16'hFFFE));
    drive(1'b1, 1'b1, 16'h8000, 16'h0001, 4'h9, pack(4'h9, 1'b0, 1'b1, 1'b1, 16'h7FFF));
    idle(6);

    // Bubble pattern
    for (int i = 0; i < 8; i++) issue_rand(pattern[i]);
    idle(6);

    // Stall mid-flight
    repeat (3) issue_rand(1'b1);
    idle(1);
    stall(5);
    idle(8);

    // Random stream with bubbles and stalls
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) stall($urandom_range(1, 3));
      else        issue_rand(r > 2);
    end
    idle(8);

    // Asynchronous reset while results are in flight and on the outputs
    repeat (6) issue_rand(1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("reset_clear", 64'({out_valid, tag_out, zero, ovf, cout, out}), 64'(0));
    exp_q.delete();
    due_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(8);

    idle(STAGES + 2);
    check("drain", 64'(due_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
